// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types: register-file index width.
package cpu_types_pkg;
  localparam int REG_W = 5;
  typedef logic [REG_W-1:0] regbits_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// Pipeline control types: hazard FSM states and the load-use detection helper.
package diaosi_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DHELD   = 2'd2,
    HALT    = 2'd3
  } hazard_state_t;

  // r0 is hard-wired zero, so a load targeting it can never create a dependency.
  function automatic logic load_use_hazard(input logic     memread,
                                           input regbits_t wsel,
                                           input regbits_t rsel1,
                                           input regbits_t rsel2);
    return memread && (wsel != '0) && ((wsel == rsel1) || (wsel == rsel2));
  endfunction
endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the hazard control unit and the pipeline.
// Performance counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_control_unit_if #(parameter int CNT_W = 32);
  logic                    ihit;
  logic                    dhit;
  logic                    mem_dreq;
  logic                    ex_memread;
  cpu_types_pkg::regbits_t ex_wsel;
  cpu_types_pkg::regbits_t id_rsel1;
  cpu_types_pkg::regbits_t id_rsel2;
  logic                    ex_pcsrc;
  logic                    halt;
  logic                    pc_en;
  logic                    ifid_en;
  logic                    idex_en;
  logic                    exmem_en;
  logic                    memwb_en;
  logic                    ifid_flush;
  logic                    idex_flush;
  logic                    dreq_mask;
  logic                    halted;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;

  modport hcu (
    input  ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rsel1, id_rsel2, ex_pcsrc, halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    output dreq_mask, halted, stall_cnt, flush_cnt
  );
  modport tb (
    output ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rsel1, id_rsel2, ex_pcsrc, halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    input  dreq_mask, halted, stall_cnt, flush_cnt
  );
`else
  localparam int unused_cnt_w = CNT_W;

  modport hcu (
    input  ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rsel1, id_rsel2, ex_pcsrc, halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    output dreq_mask, halted
  );
  modport tb (
    output ihit, dhit, mem_dreq, ex_memread, ex_wsel, id_rsel1, id_rsel2, ex_pcsrc, halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    input  dreq_mask, halted
  );
`endif
endinterface

// File: rtl/hazard_control_unit_perf_counter.sv
// Saturating event counter used for stall/flush statistics.
// Compiled only when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule
`endif

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait freeze, load-use stall, branch flush and halt.
// Define HAZARD_PERF_EN to add saturating stall/flush counters.
module hazard_control_unit
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               CLK,
  input logic               nRST,
  hazard_control_unit_if.hcu hif
);
  hazard_state_t state_q, state_d;
  logic          halted_q, halted_d;
  logic          advance;
  logic          load_use;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, dreq_mask;

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    dreq_mask  = 1'b0;
    load_use   = load_use_hazard(hif.ex_memread, hif.ex_wsel, hif.id_rsel1, hif.id_rsel2);
    // In DHELD the data side already completed, so only the fetch is awaited.
    advance    = hif.ihit && (!hif.mem_dreq || hif.dhit || (state_q == DHELD));

    if (state_q != HALT) begin
      if (state_q == DHELD) dreq_mask = 1'b1;

      if (!advance) begin
        if ((state_q != DHELD) && hif.dhit && !hif.ihit) state_d = DHELD;
      end else if (hif.ex_pcsrc) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = RUN;
      end else if (load_use && (state_q != LDSTALL)) begin
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush = 1'b1;
        state_d    = LDSTALL;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        state_d = RUN;
      end

      if (hif.halt) state_d = HALT;
    end

    // Keep the pipeline and memory quiet while reset is held.
    if (!nRST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      dreq_mask  = 1'b0;
    end

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign hif.pc_en      = pc_en;
  assign hif.ifid_en    = ifid_en;
  assign hif.idex_en    = idex_en;
  assign hif.exmem_en   = exmem_en;
  assign hif.memwb_en   = memwb_en;
  assign hif.ifid_flush = ifid_flush;
  assign hif.idex_flush = idex_flush;
  assign hif.dreq_mask  = dreq_mask;
  assign hif.halted     = halted_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (!pc_en && (state_q != HALT)),
    .cnt  (hif.stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (ifid_flush),
    .cnt  (hif.flush_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule
